// File: rtl/sid_demux2_pkg.sv
// Shared types and constants for the two-way SID packet demultiplexer.
package sid_demux2_pkg;

  localparam int unsigned CHDR_W   = 65;
  localparam int unsigned LAST_BIT = 64;
  localparam int unsigned SID_LSB  = 0;
  localparam int unsigned SID_W    = 16;
  localparam int unsigned BODY_W   = CHDR_W - SID_W - 1;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_FWD0 = 2'd1;
  localparam logic [1:0] STATE_FWD1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = STATE_IDLE,
    FWD0 = STATE_FWD0,
    FWD1 = STATE_FWD1
  } state_e;

  // One stream beat: last flag on top, SID in the low field of a header beat.
  typedef struct packed {
    logic              last;
    logic [BODY_W-1:0] body;
    logic [SID_W-1:0]  sid;
  } chdr_beat_t;

endpackage : sid_demux2_pkg

// File: rtl/sid_demux2_if.sv
// Valid/ready stream carrying 65-bit beats; master drives data, slave drives ready.
interface sid_demux2_if;
  import sid_demux2_pkg::*;

  logic [CHDR_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface : sid_demux2_if

// File: rtl/sid_demux2_slice.sv
// Two-entry skid buffer: registered output stage plus one overflow entry.
// Accepts one beat per cycle while the consumer keeps up; full_c is
// purely registered so it never depends on the consumer's ready.
module sid_demux2_slice
  import sid_demux2_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  chdr_beat_t in_tdata,
  input  logic       in_push,
  output logic       full_c,
  sid_demux2_if.master out
);

  logic       out_valid_q;
  logic       skid_valid_q;
  chdr_beat_t out_data_q;
  chdr_beat_t skid_data_q;
  logic       pop_c;
  logic       load_out_c;

  assign full_c     = out_valid_q && skid_valid_q;
  assign pop_c      = out_valid_q && out.tready;
  assign load_out_c = pop_c || !out_valid_q;

  assign out.tvalid = out_valid_q;
  assign out.tdata  = out_data_q;

  // Output stage refills from the skid entry first so beat order is preserved.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else if (clear) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else if (load_out_c) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        skid_valid_q <= in_push;
        if (in_push) begin
          skid_data_q <= in_tdata;
        end
      end else begin
        out_valid_q <= in_push;
        if (in_push) begin
          out_data_q <= in_tdata;
        end
      end
    end else if (in_push) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_tdata;
    end
  end

endmodule : sid_demux2_slice

// File: rtl/sid_demux2.sv
// Steers whole packets to one of two outputs by the SID in the header beat.
// Optional per-port packet counters: define SID_DEMUX2_PKT_COUNT_EN.
module sid_demux2
  import sid_demux2_pkg::*;
#(
  parameter logic [SID_W-1:0] SID_0        = 16'h00A0,
  parameter logic [SID_W-1:0] SID_1        = 16'h00B0,
  parameter int unsigned      DEFAULT_PORT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  sid_demux2_if.slave  i,
  sid_demux2_if.master o0,
  sid_demux2_if.master o1,
  output logic [15:0] miss_count
`ifdef SID_DEMUX2_PKT_COUNT_EN
  ,
  output logic [15:0] pkt_count0,
  output logic [15:0] pkt_count1
`endif
);

  state_e     state_q;
  state_e     state_d;
  chdr_beat_t beat_c;
  logic       hit0_c;
  logic       hit1_c;
  logic       hdr_miss_c;
  logic       hdr_port_c;
  logic       sel_port_c;
  logic       full0_c;
  logic       full1_c;
  logic       in_xfer_c;
  logic       push0_c;
  logic       push1_c;
  logic [15:0] miss_q;

  assign beat_c = i.tdata;

  // Header decode; SID_0 takes priority when both SIDs are equal.
  always_comb begin
    hit0_c     = (beat_c.sid == SID_0);
    hit1_c     = !hit0_c && (beat_c.sid == SID_1);
    hdr_miss_c = !hit0_c && !hit1_c;
    hdr_port_c = hit0_c ? 1'b0 : (hit1_c ? 1'b1 : 1'(DEFAULT_PORT));
  end

  // Port select: decoded header in IDLE, latched packet port otherwise.
  always_comb begin
    sel_port_c = hdr_port_c;
    case (state_q)
      FWD0:    sel_port_c = 1'b0;
      FWD1:    sel_port_c = 1'b1;
      default: sel_port_c = hdr_port_c;
    endcase
  end

  // A stalled destination stalls the input (intentional head-of-line blocking).
  assign i.tready  = reset_n && !clear && !(sel_port_c ? full1_c : full0_c);
  assign in_xfer_c = i.tvalid && i.tready;
  assign push0_c   = in_xfer_c && !sel_port_c;
  assign push1_c   = in_xfer_c && sel_port_c;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: lock onto a port after a multi-beat header, release on last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_xfer_c && !beat_c.last) begin
          state_d = hdr_port_c ? FWD1 : FWD0;
        end
      end
      FWD0, FWD1: begin
        if (in_xfer_c && beat_c.last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Count headers that fell through to the default port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_q <= '0;
    end else if (clear) begin
      miss_q <= '0;
    end else if (in_xfer_c && (state_q == IDLE) && hdr_miss_c) begin
      miss_q <= miss_q + 16'd1;
    end
  end

  assign miss_count = miss_q;

  sid_demux2_slice u_slice0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .in_tdata (beat_c),
    .in_push  (push0_c),
    .full_c   (full0_c),
    .out      (o0)
  );

  sid_demux2_slice u_slice1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .in_tdata (beat_c),
    .in_push  (push1_c),
    .full_c   (full1_c),
    .out      (o1)
  );

`ifdef SID_DEMUX2_PKT_COUNT_EN
  logic [15:0] pkt0_q;
  logic [15:0] pkt1_q;

  // Count completed packets leaving each output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt0_q <= '0;
      pkt1_q <= '0;
    end else if (clear) begin
      pkt0_q <= '0;
      pkt1_q <= '0;
    end else begin
      if (o0.tvalid && o0.tready && o0.tdata[LAST_BIT]) begin
        pkt0_q <= pkt0_q + 16'd1;
      end
      if (o1.tvalid && o1.tready && o1.tdata[LAST_BIT]) begin
        pkt1_q <= pkt1_q + 16'd1;
      end
    end
  end

  assign pkt_count0 = pkt0_q;
  assign pkt_count1 = pkt1_q;
`endif

endmodule : sid_demux2

// File: tb/tb_sid_demux2.sv
// Scoreboard bench for sid_demux2 (SID_0=0x00A0, SID_1=0x00B0, DEFAULT_PORT=0).
module tb_sid_demux2;
  import sid_demux2_pkg::*;

  localparam logic [15:0] SID_A    = 16'h00A0;
  localparam logic [15:0] SID_B    = 16'h00B0;
  localparam bit          DEF_PORT = 1'b0;

  typedef struct {
    logic [CHDR_W-1:0] d;
    bit                p;
    bit                miss;
  } beat_t;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic        clear   = 1'b0;
  logic [15:0] miss_count;
`ifdef SID_DEMUX2_PKT_COUNT_EN
  logic [15:0] pkt_count0;
  logic [15:0] pkt_count1;
`endif

  sid_demux2_if i_if ();
  sid_demux2_if o0_if ();
  sid_demux2_if o1_if ();

  sid_demux2 #(
    .SID_0        (SID_A),
    .SID_1        (SID_B),
    .DEFAULT_PORT (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .i          (i_if),
    .o0         (o0_if),
    .o1         (o1_if),
    .miss_count (miss_count)
`ifdef SID_DEMUX2_PKT_COUNT_EN
    ,
    .pkt_count0 (pkt_count0),
    .pkt_count1 (pkt_count1)
`endif
  );

  always #5 clk = ~clk;

  beat_t             stim_q[$];
  logic [CHDR_W-1:0] q0[$];
  logic [CHDR_W-1:0] q1[$];
  int                n_cmp = 0;
  int                n_err = 0;
  int                n_acc = 0;
  int                rdy_mode0 = 1;
  int                rdy_mode1 = 1;
  logic [15:0]       exp_miss = '0;
  bit                acc_prev0, acc_prev1, hold_prev0, hold_prev1;
  logic [CHDR_W-1:0] hold_data0, hold_data1;

  // Queue a packet; expected port and miss come from the routing rule.
  task automatic add_pkt(input logic [15:0] sid, input int len, input int tag);
    beat_t e;
    bit    p;
    bit    m;
    m = (sid != SID_A) && (sid != SID_B);
    p = (sid == SID_A) ? 1'b0 : ((sid == SID_B) ? 1'b1 : DEF_PORT);
    for (int b = 0; b < len; b++) begin
      e.d         = '0;
      e.d[64]     = (b == len - 1);
      e.d[47:32]  = 16'(tag);
      e.d[31:16]  = 16'(b);
      e.d[15:0]   = (b == 0) ? sid : 16'($urandom);
      e.p         = p;
      e.miss      = m && (b == 0);
      stim_q.push_back(e);
    end
  endtask

  // Forget all in-flight expectations after a reset or clear.
  task automatic model_reset();
    stim_q.delete();
    q0.delete();
    q1.delete();
    exp_miss   = '0;
    acc_prev0  = 1'b0;
    acc_prev1  = 1'b0;
    hold_prev0 = 1'b0;
    hold_prev1 = 1'b0;
  endtask

  // One clock: drive at negedge, then score outputs and record accepted input.
  task automatic cycle();
    beat_t             e;
    logic [CHDR_W-1:0] x;
    @(negedge clk);
    if (stim_q.size() != 0) begin
      i_if.tvalid = 1'b1;
      i_if.tdata  = stim_q[0].d;
    end else begin
      i_if.tvalid = 1'b0;
      i_if.tdata  = '0;
    end
    o0_if.tready = (rdy_mode0 == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode0 == 1);
    o1_if.tready = (rdy_mode1 == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode1 == 1);
    #1;
    if (acc_prev0) begin
      n_cmp++;
      if (o0_if.tvalid !== 1'b1) begin
        n_err++;
        $display("FAIL latency0: o0_tvalid=%b, required 1", o0_if.tvalid);
      end
    end
    if (acc_prev1) begin
      n_cmp++;
      if (o1_if.tvalid !== 1'b1) begin
        n_err++;
        $display("FAIL latency1: o1_tvalid=%b, required 1", o1_if.tvalid);
      end
    end
    if (hold_prev0) begin
      n_cmp++;
      if (o0_if.tvalid !== 1'b1 || o0_if.tdata !== hold_data0) begin
        n_err++;
        $display("FAIL stable0: got v=%b d=%h, required v=1 d=%h", o0_if.tvalid, o0_if.tdata, hold_data0);
      end
    end
    if (hold_prev1) begin
      n_cmp++;
      if (o1_if.tvalid !== 1'b1 || o1_if.tdata !== hold_data1) begin
        n_err++;
        $display("FAIL stable1: got v=%b d=%h, required v=1 d=%h", o1_if.tvalid, o1_if.tdata, hold_data1);
      end
    end
    if (o0_if.tvalid && o0_if.tready) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL o0_unexpected: got beat %h, required none", o0_if.tdata);
      end else begin
        x = q0.pop_front();
        if (o0_if.tdata !== x) begin
          n_err++;
          $display("FAIL o0_data: got %h, required %h", o0_if.tdata, x);
        end
      end
    end
    if (o1_if.tvalid && o1_if.tready) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL o1_unexpected: got beat %h, required none", o1_if.tdata);
      end else begin
        x = q1.pop_front();
        if (o1_if.tdata !== x) begin
          n_err++;
          $display("FAIL o1_data: got %h, required %h", o1_if.tdata, x);
        end
      end
    end
    hold_prev0 = o0_if.tvalid && !o0_if.tready;
    hold_prev1 = o1_if.tvalid && !o1_if.tready;
    hold_data0 = o0_if.tdata;
    hold_data1 = o1_if.tdata;
    acc_prev0  = 1'b0;
    acc_prev1  = 1'b0;
    if (i_if.tvalid && i_if.tready) begin
      e = stim_q.pop_front();
      if (e.p) q1.push_back(e.d);
      else     q0.push_back(e.d);
      acc_prev0 = !e.p;
      acc_prev1 = e.p;
      if (e.miss) exp_miss = exp_miss + 16'd1;
      n_acc++;
    end
  endtask

  // Run until stimulus and scoreboards are empty, within a cycle budget.
  task automatic drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while ((stim_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < max_cyc) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (stim_q.size() != 0 || q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: left stim=%0d q0=%0d q1=%0d, required 0/0/0",
               name, stim_q.size(), q0.size(), q1.size());
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear       = 1'b1;
    i_if.tvalid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    i_if.tvalid  = 1'b1;
    i_if.tdata   = {1'b0, 48'h0, SID_A};
    o0_if.tready = 1'b1;
    o1_if.tready = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (i_if.tready !== 1'b0) begin
      n_err++; $display("FAIL reset_tready: got %b, required 0", i_if.tready);
    end
    n_cmp++;
    if (o0_if.tvalid !== 1'b0 || o1_if.tvalid !== 1'b0) begin
      n_err++; $display("FAIL reset_tvalid: got %b%b, required 00", o0_if.tvalid, o1_if.tvalid);
    end
    n_cmp++;
    if (o0_if.tdata !== '0 || o1_if.tdata !== '0) begin
      n_err++; $display("FAIL reset_tdata: got %h / %h, required 0", o0_if.tdata, o1_if.tdata);
    end
    n_cmp++;
    if (miss_count !== 16'h0000) begin
      n_err++; $display("FAIL reset_miss: got %h, required 0000", miss_count);
    end
    @(negedge clk);
    i_if.tvalid = 1'b0;
    reset_n     = 1'b1;
    model_reset();
  endtask

  task automatic test_two_packets();
    int base;
    rdy_mode0 = 1; rdy_mode1 = 1;
    add_pkt(SID_A, 4, 1);
    add_pkt(SID_B, 4, 2);
    base = n_acc;
    repeat (8) cycle();
    n_cmp++;
    if (n_acc - base !== 8) begin
      n_err++; $display("FAIL two_pkt_rate: accepted %0d in 8 cycles, required 8", n_acc - base);
    end
    drain(40, "two_pkt");
    n_cmp++;
    if (miss_count !== 16'h0000) begin
      n_err++; $display("FAIL two_pkt_miss: got %h, required 0000", miss_count);
    end
  endtask

  task automatic test_single_then_multi();
    int base;
    add_pkt(SID_B, 1, 3);
    add_pkt(SID_A, 3, 4);
    base = n_acc;
    repeat (4) cycle();
    n_cmp++;
    if (n_acc - base !== 4) begin
      n_err++; $display("FAIL single_multi_rate: accepted %0d in 4 cycles, required 4", n_acc - base);
    end
    drain(40, "single_multi");
    add_pkt(SID_B, 2, 5);
    drain(40, "after_multi");
  endtask

  task automatic test_miss();
    add_pkt(16'h1234, 3, 6);
    drain(40, "miss");
    n_cmp++;
    if (miss_count !== 16'h0001) begin
      n_err++; $display("FAIL miss_count: got %h, required 0001", miss_count);
    end
  endtask

  task automatic test_backpressure();
    int base;
    rdy_mode0 = 0; rdy_mode1 = 1;
    add_pkt(SID_A, 4, 7);
    add_pkt(SID_B, 2, 8);
    base = n_acc;
    repeat (6) cycle();
    n_cmp++;
    if (n_acc - base !== 2) begin
      n_err++; $display("FAIL hol_accepted: got %0d, required 2", n_acc - base);
    end
    n_cmp++;
    if (i_if.tready !== 1'b0) begin
      n_err++; $display("FAIL hol_tready: got %b, required 0", i_if.tready);
    end
    n_cmp++;
    if (o1_if.tvalid !== 1'b0) begin
      n_err++; $display("FAIL hol_o1_idle: got %b, required 0", o1_if.tvalid);
    end
    rdy_mode0 = 1;
    drain(60, "hol");
  endtask

  task automatic test_clear();
    rdy_mode0 = 0; rdy_mode1 = 1;
    add_pkt(SID_A, 4, 9);
    repeat (3) cycle();
    @(negedge clk);
    clear = 1'b1;
    #1;
    n_cmp++;
    if (i_if.tready !== 1'b0) begin
      n_err++; $display("FAIL clear_tready: got %b, required 0", i_if.tready);
    end
    @(negedge clk);
    clear       = 1'b0;
    i_if.tvalid = 1'b0;
    #1;
    n_cmp++;
    if (o0_if.tvalid !== 1'b0 || o0_if.tdata !== '0) begin
      n_err++; $display("FAIL clear_o0: got v=%b d=%h, required v=0 d=0", o0_if.tvalid, o0_if.tdata);
    end
    n_cmp++;
    if (miss_count !== 16'h0000) begin
      n_err++; $display("FAIL clear_miss: got %h, required 0000", miss_count);
    end
    model_reset();
    rdy_mode0 = 1;
    add_pkt(SID_B, 2, 10);
    drain(40, "post_clear");
  endtask

  task automatic test_async_reset();
    rdy_mode0 = 0; rdy_mode1 = 1;
    add_pkt(SID_A, 4, 11);
    repeat (3) cycle();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (o0_if.tvalid !== 1'b0 || o0_if.tdata !== '0) begin
      n_err++; $display("FAIL areset_o0: got v=%b d=%h, required v=0 d=0", o0_if.tvalid, o0_if.tdata);
    end
    n_cmp++;
    if (i_if.tready !== 1'b0) begin
      n_err++; $display("FAIL areset_tready: got %b, required 0", i_if.tready);
    end
    model_reset();
    i_if.tvalid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    rdy_mode0 = 1;
    add_pkt(SID_B, 2, 12);
    drain(40, "post_areset");
  endtask

  task automatic test_miss_wrap();
    do_clear();
    rdy_mode0 = 1; rdy_mode1 = 1;
    for (int k = 0; k < 65535; k++) add_pkt(16'h1234, 1, k);
    drain(70000, "wrap_fill");
    n_cmp++;
    if (miss_count !== 16'hFFFF) begin
      n_err++; $display("FAIL wrap_full: got %h, required ffff", miss_count);
    end
    add_pkt(16'h1234, 1, 13);
    drain(20, "wrap");
    n_cmp++;
    if (miss_count !== 16'h0000) begin
      n_err++; $display("FAIL wrap_zero: got %h, required 0000", miss_count);
    end
  endtask

`ifdef SID_DEMUX2_PKT_COUNT_EN
  task automatic test_pkt_count();
    logic [15:0] sids [8];
    do_clear();
    rdy_mode0 = 2; rdy_mode1 = 2;
    sids = '{SID_A, SID_B, SID_A, SID_A, SID_B, SID_A, SID_B, SID_A};
    for (int n = 0; n < 8; n++) add_pkt(sids[n], 1 + n % 3, 20 + n);
    drain(600, "pkt_count");
    cycle();
    n_cmp++;
    if (pkt_count0 !== 16'd5 || pkt_count1 !== 16'd3) begin
      n_err++; $display("FAIL pkt_count: got %0d/%0d, required 5/3", pkt_count0, pkt_count1);
    end
    do_clear();
    #1;
    n_cmp++;
    if (pkt_count0 !== 16'd0 || pkt_count1 !== 16'd0) begin
      n_err++; $display("FAIL pkt_count_clear: got %0d/%0d, required 0/0", pkt_count0, pkt_count1);
    end
  endtask
`endif

  initial begin
    i_if.tvalid  = 1'b0;
    i_if.tdata   = '0;
    o0_if.tready = 1'b1;
    o1_if.tready = 1'b1;
    model_reset();
    test_reset();
    test_two_packets();
    test_single_then_multi();
    test_miss();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_miss_wrap();
`ifdef SID_DEMUX2_PKT_COUNT_EN
    test_pkt_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sid_demux2

// File: doc/sid_demux2.md
Name: sid_demux2

Overview:
- Downstream consumer of the bad-SID filter stage. Takes its 65-bit packet stream: bit 64 = last, first beat carries the SID in [15:0].
- Steers each whole packet to one of two output ports by SID: SID_0 goes to port 0, SID_1 to port 1, anything else to DEFAULT_PORT.
- Each output is registered through a 2-entry skid slice, which breaks combinational paths toward the two consumers.

Parameters:
- SID_0, 16'h00A0, SID routed to output 0
- SID_1, 16'h00B0, SID routed to output 1
- DEFAULT_PORT, 0, port (0/1) for packets whose SID matches neither

Ports:
- clk  in  1  single clock domain
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear; same effect as reset, sampled on clk
- i_tdata  in  65  [64]=last, [15:0]=SID on header beat
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o0_tdata  out  65  port 0 data
- o0_tvalid  out  1  port 0 valid
- o0_tready  in  1  port 0 ready
- o1_tdata  out  65  port 1 data
- o1_tvalid  out  1  port 1 valid
- o1_tready  in  1  port 1 ready
- miss_count  out  16  packets that took DEFAULT_PORT because of no SID match

Behaviour:
- Handshake: beat transfers when i_tvalid && i_tready. Outputs follow AXI-stream rules: o*_tdata is held stable while o*_tvalid && !o*_tready.
- State machine: IDLE, FWD0, FWD1.
  - IDLE: current beat is a header. Destination is decoded combinationally from i_tdata[15:0].
  - i_tready = !full of the destination slice.
  - On transfer with last=0: go to FWD0 or FWD1.
  - On transfer with last=1 (single-beat packet): stay in IDLE.
  - FWD0/FWD1: i_tready = !full of the selected slice. Beats go only to that port. Transfer with last=1 returns to IDLE.
- A packet never changes port mid-flight. The non-selected port never receives a beat.
- Head-of-line blocking is intended: a stalled destination stalls the input, even if the other port is free.
- Output slice:
  - 2-entry skid buffer; latency is exactly 1 cycle from input transfer to o*_tvalid.
  - Full throughput: 1 beat/cycle when the consumer is always ready.
  - full = both entries occupied.
- miss_count:
  - Increments by 1 on each header transfer whose SID equals neither SID_0 nor SID_1.
  - 16-bit, wraps 16'hFFFF -> 16'h0000.
- If SID_0 == SID_1, port 0 wins.
- Reset/clear values: state=IDLE; both slices emptied; o0_tvalid=o1_tvalid=0; o*_tdata=0; miss_count=0.
- Reset or clear mid-packet drops the remainder of the packet. The next accepted beat is treated as a header.
- i_tready is 0 while reset_n is low.

Optional Feature:
- Macro SID_DEMUX2_PKT_COUNT_EN.
- When defined: adds outputs pkt_count0[15:0] and pkt_count1[15:0].
  - Each increments on every last-beat transfer at the corresponding output (o*_tvalid && o*_tready && o*_tdata[64]).
  - Both wrap at 16 bits and reset/clear to 0.
- When undefined: these ports and counters do not exist, and the rest of the behaviour is unchanged.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, FWD0=1, FWD1=2)
  - CHDR_W=65, LAST_BIT=64
  - SID field slice constants (SID_LSB=0, SID_W=16)
- One sub-module: sid_demux2_slice, the 2-entry skid buffer, instantiated once per output.

Test Plan:
- Two 4-beat packets, SIDs 0x00A0 then 0x00B0, both outputs always ready -> packet 1 on o0 and packet 2 on o1, intact; 1-cycle latency; 8 consecutive input cycles accepted; miss_count=0.
- Single-beat packet SID 0x00B0 (last=1), followed immediately by a 3-beat packet SID 0x00A0 -> 1 beat on o1, then 3 beats on o0; state back to IDLE after each packet.
- Packet with SID 0x1234, DEFAULT_PORT=0 -> all beats on o0; miss_count=1. Preload 16'hFFFF, send one more miss -> miss_count=0.
- o0_tready held 0 while a SID 0x00A0 packet is in progress, with SID 0x00B0 packet queued behind it -> i_tready=0 once the slice fills; o1 stays idle; o0_tdata stays stable. Release o0_tready -> both packets delivered in order.
- Assert reset_n low asynchronously mid-packet, with o0 holding 2 beats -> o0_tvalid=0 immediately. After release, next beat (SID 0x00B0) is routed as a header to o1.
- With SID_DEMUX2_PKT_COUNT_EN: 5 packets to o0 and 3 to o1, with random tready -> pkt_count0=5, pkt_count1=3. Assert clear -> both 0.
